// File: rtl/spi_reg_pkg.sv
// Shared definitions for SPI-slave register banks: opcodes, frame constants
// and the per-bit set/clear/toggle rule.
package spi_reg_pkg;

  localparam int ADDR_W = 8;
  localparam int MAX_W  = 16;

  localparam logic [1:0] OP_UPDATE = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_SRST   = 2'b11;

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_IDLE,
    ST_FRAME
  } link_state_e;

  // set&clr toggles, set alone forces 1, clr alone forces 0, neither holds.
  function automatic logic [MAX_W-1:0] bit_update(input logic [MAX_W-1:0] x,
                                                  input logic [MAX_W-1:0] set,
                                                  input logic [MAX_W-1:0] clr);
    return (x & ~(set | clr)) | (set & ~clr) | (~x & set & clr);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third history flop giving one-clk rise/fall pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// Oversampled SPI mode-1 slave driving a parametrised bank of control registers
// with update/write/read/soft-reset opcodes and exact frame-length checking.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                      NREG      = 16,
  parameter int                      REG_W     = 4,
  parameter logic [NREG*REG_W-1:0]   RESET_VAL = '0,
  parameter logic [NREG-1:0]         KEEP_MASK = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [NREG*REG_W-1:0] reg_q,
  output logic [NREG-1:0]       wr_strobe,
  output logic                  frame_err
);

  localparam int FRAME_W = ADDR_W + 2 * REG_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_sclk),
    .q_o    (sclk_q),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_cs_n),
    .q_o    (cs_q),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_mosi),
    .q_o    (mosi_q),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_sig;
  assign unused_sig = ^{sclk_q, mosi_rise, mosi_fall};

  link_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [REG_W-1:0]   shadow_q, shadow_d;
  logic               miso_q, miso_d;
  logic               err_q, err_d;

  logic [5:0]         idx_new;
  logic [REG_W-1:0]   rd_data;
  logic               frame_end, len_ok, commit;
  logic [1:0]         op;
  logic [5:0]         idx;
  logic [REG_W-1:0]   clr_f, set_f;

  // Index of the address byte completing on this sample; reads the live bank.
  assign idx_new = {shift_q[4:0], mosi_q};

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx_new == 6'(i)) begin
        rd_data = reg_q[i*REG_W +: REG_W];
      end
    end
  end

  assign op    = shift_q[FRAME_W-1 -: 2];
  assign idx   = shift_q[FRAME_W-3 -: 6];
  assign clr_f = shift_q[2*REG_W-1 -: REG_W];
  assign set_f = shift_q[REG_W-1:0];

  assign frame_end = cs_rise && (state_q == ST_FRAME);
  assign len_ok    = (cnt_q == CNT_W'(FRAME_W));
  assign commit    = frame_end && len_ok;
  assign err_d     = frame_end && !len_ok;

  // DISARMED guards against a frame already in progress at reset release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISARMED: if (cs_q)    state_d = ST_IDLE;
      ST_IDLE:     if (cs_fall) state_d = ST_FRAME;
      ST_FRAME:    if (cs_rise) state_d = ST_IDLE;
      default:                  state_d = ST_DISARMED;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    miso_d   = miso_q;
    if (state_q != ST_FRAME) begin
      cnt_d    = '0;
      shift_d  = '0;
      shadow_d = '0;
      miso_d   = 1'b0;
    end else if (sclk_fall && !cs_q) begin
      shift_d = {shift_q[FRAME_W-2:0], mosi_q};
      if (cnt_q != CNT_W'(FRAME_W + 1)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q == CNT_W'(ADDR_W - 1)) begin
        shadow_d = rd_data;
      end
    end else if (sclk_rise && !cs_q) begin
      miso_d   = shadow_q[REG_W-1];
      shadow_d = shadow_q << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_DISARMED;
      cnt_q    <= '0;
      shift_q  <= '0;
      shadow_q <= '0;
      miso_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      miso_q   <= miso_d;
      err_q    <= err_d;
    end
  end

  assign spi_miso  = miso_q;
  assign frame_err = err_q;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [REG_W-1:0] val_q, val_d;
    logic             strobe_q, strobe_d;

    always_comb begin
      val_d    = val_q;
      strobe_d = 1'b0;
      if (commit) begin
        case (op)
          OP_UPDATE: if (idx == 6'(gi)) begin
            val_d    = REG_W'(bit_update(MAX_W'(val_q), MAX_W'(set_f), MAX_W'(clr_f)));
            strobe_d = 1'b1;
          end
          OP_WRITE: if (idx == 6'(gi)) begin
            val_d    = set_f;
            strobe_d = 1'b1;
          end
          OP_SRST: if (!KEEP_MASK[gi]) begin
            val_d    = RESET_VAL[gi*REG_W +: REG_W];
            strobe_d = 1'b1;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_q    <= RESET_VAL[gi*REG_W +: REG_W];
        strobe_q <= 1'b0;
      end else begin
        val_q    <= val_d;
        strobe_q <= strobe_d;
      end
    end

    assign reg_q[gi*REG_W +: REG_W] = val_q;
    assign wr_strobe[gi]            = strobe_q;
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: frames driven at sclk = clk/4, checked
// against hand-computed register images, pulse counts and readback words.
module tb_spi_reg_bank;

  localparam logic [63:0] RST_V = 64'h0000_0000_0000_A000;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [63:0] reg_q;
  logic [15:0] wr_strobe;
  logic        frame_err;

  spi_reg_bank #(
    .NREG      (16),
    .REG_W     (4),
    .RESET_VAL (RST_V),
    .KEEP_MASK (16'h0100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int strb_cnt [16];
  int err_cnt  = 0;
  int strb_base [16];
  int err_base = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (wr_strobe[i]) strb_cnt[i] = strb_cnt[i] + 1;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 16; i++) strb_base[i] = strb_cnt[i];
    err_base = err_cnt;
  endtask

  function automatic logic [15:0] strb_mask();
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) m[i] = (strb_cnt[i] != strb_base[i]);
    return m;
  endfunction

  function automatic int strb_sum();
    int s = 0;
    for (int i = 0; i < 16; i++) s += strb_cnt[i] - strb_base[i];
    return s;
  endfunction

  task automatic frame_bits(input logic [31:0] data, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int b = nbits - 1; b >= 0; b--) begin
      spi_sclk = 1'b1;
      spi_mosi = data[b];
      tick(2);
      spi_sclk = 1'b0;
      tick(2);
      rx = {rx[30:0], spi_miso};
    end
  endtask

  task automatic frame(input logic [31:0] data, input int nbits, output logic [31:0] rx);
    spi_cs_n = 1'b0;
    tick(4);
    frame_bits(data, nbits, rx);
    tick(4);
    spi_cs_n = 1'b1;
    tick(10);
  endtask

  task automatic expect_frame(input string tag, input logic [63:0] exp_reg,
                              input logic [15:0] exp_strb, input int exp_err);
    int pop = 0;
    for (int i = 0; i < 16; i++) pop += int'(exp_strb[i]);
    check_eq({tag, "_reg"}, reg_q, exp_reg);
    check_eq({tag, "_strb"}, 64'(strb_mask()), 64'(exp_strb));
    check_eq({tag, "_nstrb"}, 64'(strb_sum()), 64'(pop));
    check_eq({tag, "_err"}, 64'(err_cnt - err_base), 64'(exp_err));
  endtask

  logic [31:0] rx;

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(6);
    check_eq("rst_reg", reg_q, RST_V);
    check_eq("rst_miso", 64'(spi_miso), 64'd0);
    check_eq("rst_strb", 64'(wr_strobe), 64'd0);
    check_eq("rst_err", 64'(err_cnt), 64'd0);

    // Update frame with latency probe on the cs_n rise.
    snap();
    spi_cs_n = 1'b0;
    tick(4);
    frame_bits(32'h0705, 16, rx);
    tick(4);
    spi_cs_n = 1'b1;
    tick(2);
    check_eq("lat_before", reg_q, RST_V);
    tick(1);
    check_eq("lat_after", reg_q, 64'h5000_A000);
    tick(8);
    expect_frame("upd1", 64'h5000_A000, 16'h0080, 0);

    snap(); frame(32'h0736, 16, rx);
    expect_frame("upd2", 64'h6000_A000, 16'h0080, 0);

    snap(); frame(32'h4709, 16, rx);
    expect_frame("wr7", 64'h9000_A000, 16'h0080, 0);

    snap(); frame(32'h8700, 16, rx);
    check_eq("rd7_miso", 64'(rx[15:0]), 64'h0090);
    expect_frame("rd7", 64'h9000_A000, 16'h0000, 0);

    snap(); frame(32'h4802, 16, rx);
    frame(32'h4305, 16, rx);
    expect_frame("wr83", 64'h2_9000_5000, 16'h0108, 0);

    snap(); frame(32'h8800, 16, rx);
    check_eq("rd8_miso", 64'(rx[15:0]), 64'h0020);

    snap(); frame(32'hC000, 16, rx);
    expect_frame("srst", 64'h2_0000_A000, 16'hFEFF, 0);

    snap(); frame(32'h070F >> 1, 15, rx);
    expect_frame("len15", 64'h2_0000_A000, 16'h0000, 1);

    snap(); frame(32'h070F << 1, 17, rx);
    expect_frame("len17", 64'h2_0000_A000, 16'h0000, 1);

    snap();
    spi_cs_n = 1'b0;
    tick(4);
    spi_cs_n = 1'b1;
    tick(10);
    expect_frame("len0", 64'h2_0000_A000, 16'h0000, 1);

    snap(); frame(32'h140F, 16, rx);
    expect_frame("idx20", 64'h2_0000_A000, 16'h0000, 0);

    snap(); frame(32'h9400, 16, rx);
    check_eq("rd20_miso", 64'(rx[15:0]), 64'h0000);

    // Reset in the middle of a frame; trailing bits before cs_n rises must be ignored.
    spi_cs_n = 1'b0;
    tick(4);
    frame_bits(32'h070F >> 6, 10, rx);
    rst_n = 1'b0;
    #2;
    check_eq("async_rst", reg_q, RST_V);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    snap();
    frame_bits(32'hF, 4, rx);
    tick(4);
    spi_cs_n = 1'b1;
    tick(10);
    expect_frame("post_rst", RST_V, 16'h0000, 0);

    snap(); frame(32'h0703, 16, rx);
    expect_frame("clean", 64'h3000_A000, 16'h0080, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
